iir_sos_sched: RTL

Sample-rate scheduler for a time-multiplexed second-order-section (biquad) IIR cascade sharing one multiply-accumulate unit. It detects the falling edge of the `f_s` sampling clock, then sequences coefficient addresses, delay-line selects and MAC controls through every section. It finishes by strobing the cascade output register. It sits between the sampling-clock source and the shared MAC / coefficient ROM / state RAM datapath used by the band-pass filters.

---
 rtl/iir_sos_sched_if.sv | 23 ++
 rtl/iir_sos_sched.sv | 120 ++++++++++++
 2 files changed

// File: rtl/iir_sos_sched_if.sv
// Control bundle from the biquad scheduler to the shared MAC / coefficient ROM / state RAM datapath.
interface iir_sos_sched_if #(
  parameter int N_SEC = 4,
  parameter int CW    = $clog2(5 * N_SEC),
  parameter int SW    = (N_SEC > 1) ? $clog2(N_SEC) : 1
);
  logic          sample_ld;
  logic          mac_clr;
  logic          mac_en;
  logic [CW-1:0] coef_addr;
  logic [2:0]    st_sel;
  logic [SW-1:0] sec_idx;
  logic          st_wr;
  logic          dout_ld;

  modport master (
    output sample_ld, mac_clr, mac_en, coef_addr, st_sel, sec_idx, st_wr, dout_ld
  );

  modport slave (
    input sample_ld, mac_clr, mac_en, coef_addr, st_sel, sec_idx, st_wr, dout_ld
  );
endinterface

// File: rtl/iir_sos_sched.sv
// Sample-rate scheduler for a time-multiplexed biquad cascade: on each f_s falling edge it
// walks every section through five MAC steps and a write-back, then strobes the output register.
module iir_sos_sched #(
  parameter int N_SEC = 4,
  parameter int CW    = $clog2(5 * N_SEC),
  parameter int SW    = (N_SEC > 1) ? $clog2(N_SEC) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               f_s,
  input  logic               en,
  input  logic               ovr_clr,
  output logic               busy,
  output logic               ovr,
  iir_sos_sched_if.master    dp
);

  typedef enum logic [2:0] {IDLE, LOAD, MAC, WB, DONE} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] sec, sec_nxt;
  logic [2:0]    step, step_nxt;
  logic          pl0, pl1;
  logic          tick;

  logic          sample_ld_c, mac_clr_c, mac_en_c, st_wr_c, dout_ld_c;
  logic [CW-1:0] coef_addr_c;
  logic [2:0]    st_sel_c;
  logic [SW-1:0] sec_idx_c;

  assign tick = pl1 & ~pl0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sec   <= '0;
      step  <= '0;
      pl0   <= 1'b0;
      pl1   <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      state <= state_nxt;
      sec   <= sec_nxt;
      step  <= step_nxt;
      pl0   <= f_s;
      pl1   <= pl0;
      // A dropped tick outranks a simultaneous clear so no overrun is ever lost
      if (tick && busy)
        ovr <= 1'b1;
      else if (ovr_clr)
        ovr <= 1'b0;
    end
  end

  always_comb begin
    state_nxt   = state;
    sec_nxt     = sec;
    step_nxt    = step;
    sample_ld_c = 1'b0;
    mac_clr_c   = 1'b0;
    mac_en_c    = 1'b0;
    st_wr_c     = 1'b0;
    dout_ld_c   = 1'b0;
    coef_addr_c = '0;
    st_sel_c    = '0;
    sec_idx_c   = '0;
    busy        = (state != IDLE);
    case (state)
      IDLE: begin
        if (tick && en)
          state_nxt = LOAD;
      end
      LOAD: begin
        sample_ld_c = 1'b1;
        sec_nxt     = '0;
        step_nxt    = '0;
        state_nxt   = MAC;
      end
      MAC: begin
        mac_en_c    = 1'b1;
        mac_clr_c   = (step == 3'd0);
        coef_addr_c = CW'(sec) * CW'(5) + CW'(step);
        st_sel_c    = step;
        sec_idx_c   = sec;
        if (step == 3'd4)
          state_nxt = WB;
        else
          step_nxt = step + 3'd1;
      end
      WB: begin
        st_wr_c   = 1'b1;
        sec_idx_c = sec;
        step_nxt  = '0;
        // sec returns to 0 on the way to DONE so sec_idx reads 0 there
        if (sec == SW'(N_SEC - 1)) begin
          sec_nxt   = '0;
          state_nxt = DONE;
        end else begin
          sec_nxt   = sec + SW'(1);
          state_nxt = MAC;
        end
      end
      DONE: begin
        dout_ld_c = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign dp.sample_ld = sample_ld_c;
  assign dp.mac_clr   = mac_clr_c;
  assign dp.mac_en    = mac_en_c;
  assign dp.coef_addr = coef_addr_c;
  assign dp.st_sel    = st_sel_c;
  assign dp.sec_idx   = sec_idx_c;
  assign dp.st_wr     = st_wr_c;
  assign dp.dout_ld   = dout_ld_c;

endmodule
